// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite definitions used by the master and the matching slave.
package axi4_lite_pkg;

  localparam int DEFAULT_ADDR_WIDTH = 32;
  localparam int DEFAULT_DATA_WIDTH = 32;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_AW_W = 3'd1,
    WR_B    = 3'd2,
    RD_AR   = 3'd3,
    RD_R    = 3'd4
  } state_t;

  // Any response other than OKAY is reported to the requester as an error.
  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp != RESP_OKAY;
  endfunction

endpackage

// File: rtl/axi4_lite_master.sv
// Single-outstanding AXI4-Lite master: turns a local request into AW/W/B or
// AR/R handshakes and reports completion with a one-cycle done pulse.
module axi4_lite_master
  import axi4_lite_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                    iCLK,
  input  logic                    iRST,
  input  logic                    iWR_REQ,
  input  logic                    iRD_REQ,
  input  logic [ADDR_WIDTH-1:0]   iADDR,
  input  logic [DATA_WIDTH-1:0]   iWDATA,
  input  logic [DATA_WIDTH/8-1:0] iWSTRB,
  output logic                    oBUSY,
  output logic                    oDONE,
  output logic [DATA_WIDTH-1:0]   oRDATA,
  output logic [1:0]              oRESP,
  output logic                    oERR,
  output logic                    m_AWVALID,
  input  logic                    m_AWREADY,
  output logic [ADDR_WIDTH-1:0]   m_AWADDR,
  output logic                    m_WVALID,
  input  logic                    m_WREADY,
  output logic [DATA_WIDTH-1:0]   m_WDATA,
  output logic [DATA_WIDTH/8-1:0] m_WSTRB,
  input  logic                    m_BVALID,
  output logic                    m_BREADY,
  input  logic [1:0]              m_BRESP,
  output logic                    m_ARVALID,
  input  logic                    m_ARREADY,
  output logic [ADDR_WIDTH-1:0]   m_ARADDR,
  input  logic                    m_RVALID,
  output logic                    m_RREADY,
  input  logic [DATA_WIDTH-1:0]   m_RDATA,
  input  logic [1:0]              m_RRESP
);

  state_t state;
  state_t state_next;

  // AW and W may finish on different edges; these remember which already did.
  logic aw_done;
  logic w_done;

  logic aw_hs;
  logic w_hs;
  logic b_hs;
  logic ar_hs;
  logic r_hs;
  logic aw_complete;
  logic w_complete;

  assign aw_hs = m_AWVALID & m_AWREADY;
  assign w_hs  = m_WVALID  & m_WREADY;
  assign b_hs  = m_BVALID  & m_BREADY;
  assign ar_hs = m_ARVALID & m_ARREADY;
  assign r_hs  = m_RVALID  & m_RREADY;

  assign aw_complete = aw_done | aw_hs;
  assign w_complete  = w_done  | w_hs;

  // Busy drops in the same cycle the done pulse is high, since both follow the return to IDLE.
  assign oBUSY = (state != IDLE);

  // State register.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode; a write wins over a simultaneous read request.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (iWR_REQ) begin
          state_next = WR_AW_W;
        end else if (iRD_REQ) begin
          state_next = RD_AR;
        end
      end
      WR_AW_W: begin
        if (aw_complete && w_complete) begin
          state_next = WR_B;
        end
      end
      WR_B: begin
        if (b_hs) begin
          state_next = IDLE;
        end
      end
      RD_AR: begin
        if (ar_hs) begin
          state_next = RD_R;
        end
      end
      RD_R: begin
        if (r_hs) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Registered channel outputs and the result returned to the requester.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      m_AWVALID <= 1'b0;
      m_AWADDR  <= '0;
      m_WVALID  <= 1'b0;
      m_WDATA   <= '0;
      m_WSTRB   <= '0;
      m_BREADY  <= 1'b0;
      m_ARVALID <= 1'b0;
      m_ARADDR  <= '0;
      m_RREADY  <= 1'b0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      oDONE     <= 1'b0;
      oERR      <= 1'b0;
      oRDATA    <= '0;
      oRESP     <= '0;
    end else begin
      oDONE <= 1'b0;
      oERR  <= 1'b0;
      case (state)
        IDLE: begin
          if (iWR_REQ) begin
            m_AWADDR  <= iADDR;
            m_WDATA   <= iWDATA;
            m_WSTRB   <= iWSTRB;
            m_AWVALID <= 1'b1;
            m_WVALID  <= 1'b1;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
          end else if (iRD_REQ) begin
            m_ARADDR  <= iADDR;
            m_ARVALID <= 1'b1;
          end
        end
        WR_AW_W: begin
          if (aw_hs) begin
            m_AWVALID <= 1'b0;
            aw_done   <= 1'b1;
          end
          if (w_hs) begin
            m_WVALID <= 1'b0;
            w_done   <= 1'b1;
          end
          if (aw_complete && w_complete) begin
            m_BREADY <= 1'b1;
          end
        end
        WR_B: begin
          if (b_hs) begin
            m_BREADY <= 1'b0;
            oRESP    <= m_BRESP;
            oDONE    <= 1'b1;
            oERR     <= resp_is_err(m_BRESP);
          end
        end
        RD_AR: begin
          if (ar_hs) begin
            m_ARVALID <= 1'b0;
            m_RREADY  <= 1'b1;
          end
        end
        RD_R: begin
          if (r_hs) begin
            m_RREADY <= 1'b0;
            oRDATA   <= m_RDATA;
            oRESP    <= m_RRESP;
            oDONE    <= 1'b1;
            oERR     <= resp_is_err(m_RRESP);
          end
        end
        default: begin
          m_AWVALID <= 1'b0;
          m_WVALID  <= 1'b0;
          m_BREADY  <= 1'b0;
          m_ARVALID <= 1'b0;
          m_RREADY  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi4_lite_master.sv
// Directed bench for axi4_lite_master with a small behavioural AXI4-Lite slave.
module tb_axi4_lite_master;

  logic        iCLK;
  logic        iRST;
  logic        iWR_REQ;
  logic        iRD_REQ;
  logic [31:0] iADDR;
  logic [31:0] iWDATA;
  logic [3:0]  iWSTRB;
  logic        oBUSY;
  logic        oDONE;
  logic [31:0] oRDATA;
  logic [1:0]  oRESP;
  logic        oERR;
  logic        m_AWVALID;
  logic        m_AWREADY;
  logic [31:0] m_AWADDR;
  logic        m_WVALID;
  logic        m_WREADY;
  logic [31:0] m_WDATA;
  logic [3:0]  m_WSTRB;
  logic        m_BVALID;
  logic        m_BREADY;
  logic [1:0]  m_BRESP;
  logic        m_ARVALID;
  logic        m_ARREADY;
  logic [31:0] m_ARADDR;
  logic        m_RVALID;
  logic        m_RREADY;
  logic [31:0] m_RDATA;
  logic [1:0]  m_RRESP;

  int checks = 0;
  int errors = 0;

  axi4_lite_master dut (
    .iCLK(iCLK), .iRST(iRST), .iWR_REQ(iWR_REQ), .iRD_REQ(iRD_REQ),
    .iADDR(iADDR), .iWDATA(iWDATA), .iWSTRB(iWSTRB),
    .oBUSY(oBUSY), .oDONE(oDONE), .oRDATA(oRDATA), .oRESP(oRESP), .oERR(oERR),
    .m_AWVALID(m_AWVALID), .m_AWREADY(m_AWREADY), .m_AWADDR(m_AWADDR),
    .m_WVALID(m_WVALID), .m_WREADY(m_WREADY), .m_WDATA(m_WDATA), .m_WSTRB(m_WSTRB),
    .m_BVALID(m_BVALID), .m_BREADY(m_BREADY), .m_BRESP(m_BRESP),
    .m_ARVALID(m_ARVALID), .m_ARREADY(m_ARREADY), .m_ARADDR(m_ARADDR),
    .m_RVALID(m_RVALID), .m_RREADY(m_RREADY), .m_RDATA(m_RDATA), .m_RRESP(m_RRESP)
  );

  // Free-running clock, 10 time units per period.
  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  // Slave knobs set by the stimulus code.
  int         aw_wait = 0;
  logic       b_hold = 1'b0;
  logic [1:0] resp_force = 2'b00;

  // Slave state.
  logic [31:0] mem [16];
  int          aw_cnt;
  logic        aw_got;
  logic        w_got;
  logic [31:0] aw_addr_q;
  logic [31:0] w_data_q;
  logic [3:0]  w_strb_q;
  logic        bvalid_q;
  logic [1:0]  bresp_q;
  logic        rvalid_q;
  logic [31:0] rdata_q;
  logic [1:0]  rresp_q;

  logic        have_aw;
  logic        have_w;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;

  assign m_AWREADY = m_AWVALID && !aw_got && (aw_cnt >= aw_wait);
  assign m_WREADY  = m_WVALID && !w_got;
  assign m_ARREADY = m_ARVALID && !rvalid_q;
  assign m_BVALID  = bvalid_q;
  assign m_BRESP   = bresp_q;
  assign m_RVALID  = rvalid_q;
  assign m_RDATA   = rdata_q;
  assign m_RRESP   = rresp_q;

  assign have_aw = aw_got || (m_AWVALID && m_AWREADY);
  assign have_w  = w_got  || (m_WVALID && m_WREADY);
  assign wr_addr = aw_got ? aw_addr_q : m_AWADDR;
  assign wr_data = w_got  ? w_data_q  : m_WDATA;
  assign wr_strb = w_got  ? w_strb_q  : m_WSTRB;

  // Behavioural slave: optional AW wait states, B raised the edge after both
  // AW and W are in, R raised the edge after AR, responses forced by resp_force.
  always @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
      aw_cnt    <= 0;
      aw_got    <= 1'b0;
      w_got     <= 1'b0;
      aw_addr_q <= 32'h0;
      w_data_q  <= 32'h0;
      w_strb_q  <= 4'h0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
      rvalid_q  <= 1'b0;
      rdata_q   <= 32'h0;
      rresp_q   <= 2'b00;
    end else begin
      if (m_AWVALID && !m_AWREADY) aw_cnt <= aw_cnt + 1;
      else aw_cnt <= 0;
      if (bvalid_q && m_BREADY) bvalid_q <= 1'b0;
      if (have_aw && have_w && !b_hold && !bvalid_q) begin
        for (int b = 0; b < 4; b++)
          if (wr_strb[b]) mem[wr_addr[3:0]][8*b +: 8] <= wr_data[8*b +: 8];
        bvalid_q <= 1'b1;
        bresp_q  <= resp_force;
        aw_got   <= 1'b0;
        w_got    <= 1'b0;
      end else begin
        if (m_AWVALID && m_AWREADY) begin
          aw_got    <= 1'b1;
          aw_addr_q <= m_AWADDR;
        end
        if (m_WVALID && m_WREADY) begin
          w_got    <= 1'b1;
          w_data_q <= m_WDATA;
          w_strb_q <= m_WSTRB;
        end
      end
      if (rvalid_q && m_RREADY) rvalid_q <= 1'b0;
      if (m_ARVALID && m_ARREADY) begin
        rvalid_q <= 1'b1;
        rdata_q  <= mem[m_ARADDR[3:0]];
        rresp_q  <= resp_force;
      end
    end
  end

  // Handshake counters, sampled on the active edge where the handshake happens.
  int aw_hs_cnt = 0;
  int w_hs_cnt = 0;
  int ar_hs_cnt = 0;
  always @(posedge iCLK) begin
    if (m_AWVALID && m_AWREADY) aw_hs_cnt <= aw_hs_cnt + 1;
    if (m_WVALID && m_WREADY)   w_hs_cnt  <= w_hs_cnt + 1;
    if (m_ARVALID && m_ARREADY) ar_hs_cnt <= ar_hs_cnt + 1;
  end

  // Level monitors sampled mid-cycle: valid durations, early BREADY, unstable payload, done pulses.
  logic [31:0] exp_awaddr = 32'h0;
  logic [31:0] exp_wdata = 32'h0;
  int awv_cycles = 0;
  int wv_cycles = 0;
  int arv_cycles = 0;
  int bready_early = 0;
  int unstable = 0;
  int done_cnt = 0;
  always @(negedge iCLK) begin
    if (m_AWVALID) awv_cycles <= awv_cycles + 1;
    if (m_WVALID)  wv_cycles  <= wv_cycles + 1;
    if (m_ARVALID) arv_cycles <= arv_cycles + 1;
    if (m_BREADY && (m_AWVALID || m_WVALID)) bready_early <= bready_early + 1;
    if ((m_AWVALID && m_AWADDR != exp_awaddr) || (m_WVALID && m_WDATA != exp_wdata))
      unstable <= unstable + 1;
    if (oDONE) done_cnt <= done_cnt + 1;
  end

  typedef struct {
    logic        wr;
    logic        rd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [1:0]  resp;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_resp;
    logic        exp_err;
  } vec_t;

  vec_t vecs [10];

  // Compare one value and log a FAIL line on mismatch.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Issue one request, wait (bounded) for completion and check the result and channel activity.
  task automatic applyStimulus(input vec_t v, input string tag, input int exp_lat);
    int k;
    int aw0, w0, ar0, arv0, unst0, done0;
    aw0 = aw_hs_cnt; w0 = w_hs_cnt; ar0 = ar_hs_cnt;
    arv0 = arv_cycles; unst0 = unstable; done0 = done_cnt;
    resp_force = v.resp;
    @(negedge iCLK);
    iWR_REQ = v.wr; iRD_REQ = v.rd; iADDR = v.addr; iWDATA = v.wdata; iWSTRB = v.wstrb;
    exp_awaddr = v.addr; exp_wdata = v.wdata;
    @(negedge iCLK);
    iWR_REQ = 1'b0; iRD_REQ = 1'b0; iADDR = 32'hFFFF_FFF0; iWDATA = ~v.wdata; iWSTRB = 4'h0;
    checkOutput({tag, "_busy_after_req"}, 32'(oBUSY), 32'd1);
    k = 0;
    while (!oDONE && k < 40) begin
      @(negedge iCLK);
      k++;
    end
    checkOutput({tag, "_done_seen"}, 32'(oDONE), 32'd1);
    checkOutput({tag, "_latency"}, k, exp_lat);
    checkOutput({tag, "_rdata"}, oRDATA, v.exp_rdata);
    checkOutput({tag, "_resp"}, 32'(oRESP), 32'(v.exp_resp));
    checkOutput({tag, "_err"}, 32'(oERR), 32'(v.exp_err));
    checkOutput({tag, "_busy_at_done"}, 32'(oBUSY), 32'd0);
    @(negedge iCLK);
    checkOutput({tag, "_done_single_pulse"}, 32'(oDONE), 32'd0);
    checkOutput({tag, "_done_count"}, done_cnt - done0, 32'd1);
    checkOutput({tag, "_aw_handshakes"}, aw_hs_cnt - aw0, 32'(v.wr));
    checkOutput({tag, "_w_handshakes"}, w_hs_cnt - w0, 32'(v.wr));
    checkOutput({tag, "_ar_handshakes"}, ar_hs_cnt - ar0, 32'(v.rd && !v.wr));
    checkOutput({tag, "_arvalid_cycles"}, arv_cycles - arv0, 32'(v.rd && !v.wr));
    checkOutput({tag, "_payload_stable"}, unstable - unst0, 32'd0);
  endtask

  // Global watchdog so a hung handshake still ends the run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main sequence: reset, table of transactions, then multi-cycle corner cases.
  initial begin
    vec_t v;
    int awv0, wv0, early0, done0, k;
    iRST = 1'b1; iWR_REQ = 1'b0; iRD_REQ = 1'b0;
    iADDR = 32'h0; iWDATA = 32'h0; iWSTRB = 4'h0;

    #1;
    checkOutput("reset_outputs_zero",
                32'(|{oBUSY, oDONE, oRDATA, oRESP, oERR, m_AWVALID, m_AWADDR, m_WVALID,
                      m_WDATA, m_WSTRB, m_BREADY, m_ARVALID, m_ARADDR, m_RREADY}), 32'd0);
    repeat (2) @(negedge iCLK);
    iRST = 1'b0;

    //          wr    rd    addr   wdata          strb  resp   exp_rdata      exp_resp exp_err
    vecs[0] = '{1'b1, 1'b0, 32'h1, 32'hDEADBEEF, 4'hF, 2'b00, 32'h00000000, 2'b00, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 32'h1, 32'h00000000, 4'h0, 2'b00, 32'hDEADBEEF, 2'b00, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 32'h2, 32'h11223344, 4'h5, 2'b00, 32'hDEADBEEF, 2'b00, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 32'h2, 32'h00000000, 4'h0, 2'b00, 32'h00220044, 2'b00, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 32'h4, 32'h0000ABCD, 4'hF, 2'b00, 32'h00220044, 2'b00, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 32'h4, 32'h00000000, 4'h0, 2'b00, 32'h0000ABCD, 2'b00, 1'b0};
    vecs[6] = '{1'b0, 1'b1, 32'h2, 32'h00000000, 4'h0, 2'b10, 32'h00220044, 2'b10, 1'b1};
    vecs[7] = '{1'b1, 1'b0, 32'h3, 32'hCAFEF00D, 4'hF, 2'b11, 32'h00220044, 2'b11, 1'b1};
    vecs[8] = '{1'b1, 1'b0, 32'h2, 32'hAABBCCDD, 4'hA, 2'b00, 32'h00220044, 2'b00, 1'b0};
    vecs[9] = '{1'b0, 1'b1, 32'h2, 32'h00000000, 4'h0, 2'b00, 32'hAA22CC44, 2'b00, 1'b0};

    for (int i = 0; i < 10; i++) applyStimulus(vecs[i], $sformatf("row%0d", i), 2);

    // AWREADY held off for three cycles while W is accepted at once.
    aw_wait = 3;
    awv0 = awv_cycles; wv0 = wv_cycles; early0 = bready_early;
    v = '{1'b1, 1'b0, 32'h6, 32'h0BADF00D, 4'hF, 2'b00, 32'hAA22CC44, 2'b00, 1'b0};
    applyStimulus(v, "aw_delay", 5);
    checkOutput("aw_delay_awvalid_cycles", awv_cycles - awv0, 32'd4);
    checkOutput("aw_delay_wvalid_cycles", wv_cycles - wv0, 32'd1);
    checkOutput("aw_delay_bready_early", bready_early - early0, 32'd0);
    aw_wait = 0;
    v = '{1'b0, 1'b1, 32'h6, 32'h0, 4'h0, 2'b00, 32'h0BADF00D, 2'b00, 1'b0};
    applyStimulus(v, "aw_delay_readback", 2);

    // Reset while parked in WR_B: everything clears at once and no done pulse appears.
    b_hold = 1'b1;
    done0 = done_cnt;
    @(negedge iCLK);
    iWR_REQ = 1'b1; iADDR = 32'h7; iWDATA = 32'h55AA55AA; iWSTRB = 4'hF;
    exp_awaddr = 32'h7; exp_wdata = 32'h55AA55AA;
    @(negedge iCLK);
    iWR_REQ = 1'b0;
    k = 0;
    while (!m_BREADY && k < 20) begin
      @(negedge iCLK);
      k++;
    end
    checkOutput("rst_wrb_bready_reached", 32'(m_BREADY), 32'd1);
    repeat (2) @(negedge iCLK);
    iRST = 1'b1;
    #1;
    checkOutput("rst_wrb_outputs_zero",
                32'(|{oBUSY, oDONE, oRDATA, oRESP, oERR, m_AWVALID, m_AWADDR, m_WVALID,
                      m_WDATA, m_WSTRB, m_BREADY, m_ARVALID, m_ARADDR, m_RREADY}), 32'd0);
    b_hold = 1'b0;
    repeat (2) @(negedge iCLK);
    iRST = 1'b0;
    @(negedge iCLK);
    checkOutput("rst_wrb_no_done", done_cnt - done0, 32'd0);
    v = '{1'b1, 1'b0, 32'h7, 32'h13579BDF, 4'hF, 2'b00, 32'h00000000, 2'b00, 1'b0};
    applyStimulus(v, "post_reset_write", 2);
    v = '{1'b0, 1'b1, 32'h7, 32'h0, 4'h0, 2'b00, 32'h13579BDF, 2'b00, 1'b0};
    applyStimulus(v, "post_reset_read", 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
